// File: rtl/key_step_sequencer.sv
// rtl/key_step_sequencer.sv - single-step / auto-repeat pulse generator for a debounced key
// One step per press, then repeated steps while held and repeat_en is set.
module key_step_sequencer #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 10
) (
  input  logic             CLK50M,
  input  logic             RSTb,
  input  logic             A_clean,
  input  logic             repeat_en,
  input  logic             clr_count,
  output logic             step,
  output logic [CNT_W-1:0] step_count,
  output logic             held
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_REPEAT
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               a_q, a_d;
  logic               step_q, step_d;
  logic               held_q, held_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               press_edge;

  always_comb begin
    a_d        = A_clean;
    press_edge = a_q & ~A_clean;
    state_d    = state_q;
    timer_d    = timer_q;
    step_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (press_edge) begin
          step_d  = 1'b1;
          timer_d = '0;
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (A_clean) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q >= HOLD_LAST) begin
          // Timer parks here until repeat is allowed; step_q guard keeps pulses one cycle wide.
          if (repeat_en && !step_q) begin
            step_d  = 1'b1;
            timer_d = '0;
            state_d = ST_REPEAT;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_REPEAT: begin
        if (A_clean) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (!repeat_en) begin
          state_d = ST_ARMED;
          timer_d = '0;
        end else if (timer_q >= REP_LAST) begin
          if (!step_q) begin
            step_d  = 1'b1;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    held_d = (state_d != ST_IDLE);

    // Clear wins over a coincident increment, but the step pulse itself is unaffected.
    if (clr_count) begin
      cnt_d = '0;
    end else if (step_d) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge CLK50M) begin
    if (!RSTb) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      a_q     <= 1'b0;
      step_q  <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      step_q  <= step_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign step       = step_q;
  assign held       = held_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_key_step_sequencer.sv
// tb/tb_key_step_sequencer.sv - directed plus random stimulus against a cycle-level reference model
// Model tracks press activity as elapsed cycles against the current wait period.
module tb_key_step_sequencer;

  localparam int HOLD   = 8;
  localparam int REP    = 4;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          rstb_in = 1'b0;
  logic          a_in = 1'b1;
  logic          ren = 1'b1;
  logic          clr = 1'b0;
  logic          step;
  logic [CW-1:0] step_count;
  logic          held;

  int n_tests = 0;
  int n_fail  = 0;
  int step_seen = 0;

  int m_prev_a = 0;
  int m_active = 0;
  int m_fast = 0;
  int m_elapsed = 0;
  int m_step = 0;
  int m_count = 0;
  int m_held = 0;

  always #10 clk = ~clk;

  key_step_sequencer #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (CW)
  ) dut (
    .CLK50M    (clk),
    .RSTb      (rstb_in),
    .A_clean   (a_in),
    .repeat_en (ren),
    .clr_count (clr),
    .step      (step),
    .step_count(step_count),
    .held      (held)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    int need;
    if (!rstb_in) begin
      m_prev_a  = 0;
      m_active  = 0;
      m_fast    = 0;
      m_elapsed = 0;
      m_step    = 0;
      m_count   = 0;
      m_held    = 0;
    end else begin
      m_step = 0;
      if (m_active != 0) begin
        if (a_in) begin
          m_active = 0;
        end else if (m_fast != 0 && !ren) begin
          m_fast    = 0;
          m_elapsed = 0;
        end else begin
          if (m_elapsed < 1000) m_elapsed++;
          need = (m_fast != 0) ? REP : HOLD;
          if (ren && m_elapsed >= need) begin
            m_step    = 1;
            m_fast    = 1;
            m_elapsed = 0;
          end
        end
      end else if (m_prev_a != 0 && !a_in) begin
        m_step    = 1;
        m_active  = 1;
        m_fast    = 0;
        m_elapsed = 0;
      end
      m_held = m_active;
      if (clr) m_count = 0;
      else if (m_step != 0) m_count = (m_count + 1) % (1 << CW);
      m_prev_a = a_in ? 1 : 0;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("step", 32'(step), 32'(m_step));
      chk("held", 32'(held), 32'(m_held));
      chk("count", 32'(step_count), 32'(m_count));
      if (step) step_seen++;
    end
  endtask

  initial begin
    int len;
    cyc(3);
    rstb_in = 1'b1;
    cyc(2);

    // single short press
    step_seen = 0;
    a_in = 1'b0; cyc(3);
    a_in = 1'b1; cyc(3);
    chk("r028_steps", 32'(step_seen), 32'd1);
    chk("r028_count", 32'(step_count), 32'd1);

    // long press with auto-repeat
    step_seen = 0;
    a_in = 1'b0; cyc(20);
    a_in = 1'b1; cyc(5);
    chk("r029_steps", 32'(step_seen), 32'd4);
    chk("r029_count", 32'(step_count), 32'd5);

    // long press with repeat disabled, then enabled mid-hold
    ren = 1'b0;
    step_seen = 0;
    a_in = 1'b0; cyc(20);
    chk("r030_steps", 32'(step_seen), 32'd1);
    chk("r030_held", 32'(held), 32'd1);
    ren = 1'b1; cyc(1);
    chk("r030_late", 32'(step), 32'd1);
    cyc(2);
    a_in = 1'b1; cyc(3);

    // counter wrap and clear priority
    clr = 1'b1; cyc(1);
    clr = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_in = 1'b0; cyc(2);
      a_in = 1'b1; cyc(2);
      if (k == 14) chk("r031_fifteen", 32'(step_count), 32'd15);
    end
    chk("r031_wrap", 32'(step_count), 32'd0);
    a_in = 1'b0; cyc(1);
    a_in = 1'b1; cyc(2);
    a_in = 1'b0; clr = 1'b1; cyc(1);
    clr = 1'b0;
    chk("r031_clr_step", 32'(step), 32'd1);
    chk("r031_clr_count", 32'(step_count), 32'd0);
    a_in = 1'b1; cyc(3);

    // key held low across reset
    a_in = 1'b0; rstb_in = 1'b0; cyc(3);
    rstb_in = 1'b1;
    step_seen = 0;
    cyc(10);
    chk("r032_nostep", 32'(step_seen), 32'd0);
    a_in = 1'b1; cyc(2);
    a_in = 1'b0; cyc(2);
    a_in = 1'b1; cyc(2);
    chk("r032_steps", 32'(step_seen), 32'd1);

    // reset one cycle before a repeat expiry
    a_in = 1'b0; cyc(12);
    rstb_in = 1'b0; cyc(1);
    chk("r033_step", 32'(step), 32'd0);
    chk("r033_held", 32'(held), 32'd0);
    chk("r033_count", 32'(step_count), 32'd0);
    rstb_in = 1'b1;
    step_seen = 0;
    cyc(6);
    chk("r033_after", 32'(step_seen), 32'd0);
    a_in = 1'b1; cyc(2);

    // random phase
    for (int r = 0; r < 300; r++) begin
      a_in    = 1'($urandom_range(0, 1));
      ren     = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 15) == 0);
      rstb_in = ($urandom_range(0, 40) != 0);
      len     = $urandom_range(1, 25);
      cyc(1);
      clr     = 1'b0;
      rstb_in = 1'b1;
      if (len > 1) cyc(len - 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_step_sequencer.md
KEY_STEP_SEQUENCER -- requirements
Module: key_step_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 25_000_000, cycles the key is held before auto-repeat starts (0.5 s at 50 MHz).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 5_000_000, cycles between auto-repeat steps (0.1 s).
REQ-003 SHALL have parameter CNT_W, default 10, width of step_count.
REQ-004 SHALL have port CLK50M  input  1  single 50 MHz system clock; all logic on its rising edge.
REQ-005 SHALL have port RSTb  input  1  synchronous active-low reset.
REQ-006 SHALL have port A_clean  input  1  debounced key level from the debouncer; 0 = pressed, 1 = released.
REQ-007 SHALL have port repeat_en  input  1  1 = auto-repeat allowed while held.
REQ-008 SHALL have port clr_count  input  1  synchronous clear of step_count.
REQ-009 SHALL have port step  output  1  registered one-cycle step-enable pulse for the processor clock gate.
REQ-010 SHALL have port step_count  output  CNT_W  number of steps issued, for HEX display.
REQ-011 SHALL have port held  output  1  registered, 1 while FSM is in ARMED or REPEAT.

Function
REQ-012 SHALL register A_clean into a_q every cycle; press_edge = a_q & ~A_clean.
REQ-013 SHALL implement FSM states IDLE, ARMED, REPEAT with a timer wide enough for max(HOLD_CYCLES, REPEAT_CYCLES).
REQ-014 IDLE: on press_edge SHALL assert step at the next edge, clear timer, go ARMED; otherwise stay IDLE, step=0.
REQ-015 ARMED: A_clean=1 SHALL go IDLE, no step; else timer increments.
REQ-016 ARMED: timer == HOLD_CYCLES-1 with repeat_en=1 SHALL assert step, clear timer, go REPEAT.
REQ-017 ARMED: repeat_en=0 SHALL saturate timer at HOLD_CYCLES-1 and remain ARMED with no step.
REQ-018 REPEAT: A_clean=1 SHALL go IDLE, no step, regardless of timer.
REQ-019 REPEAT: timer == REPEAT_CYCLES-1 SHALL assert step and clear timer, staying REPEAT.
REQ-020 REPEAT: repeat_en=0 SHALL go ARMED with timer cleared, no step.
REQ-021 Release takes priority over timer expiry in the same cycle (no step).
REQ-022 step SHALL never be high two consecutive cycles; latency = 1 cycle from the edge sampling the press.
REQ-023 step_count SHALL increment in the same edge that sets step, wrapping 2^CNT_W-1 -> 0.
REQ-024 clr_count SHALL force step_count to 0 and take priority over a simultaneous increment; step pulse still issued.
REQ-025 A key held low through and after reset SHALL produce no step until released and pressed again.

Reset
REQ-026 While RSTb=0 at a clock edge: state=IDLE, timer=0, step=0, held=0, step_count=0, a_q=0.
REQ-027 Reset SHALL abort ARMED/REPEAT mid-operation with no pending step emitted afterwards.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4)
REQ-028 Press A_clean 1->0 held 3 cycles then release -> exactly one step pulse one cycle after press, step_count=1, held 1 then 0.
REQ-029 Press held 20 cycles, repeat_en=1 -> steps at press+1, +9, +13, +17; step_count=4; release -> no further steps.
REQ-030 Same hold with repeat_en=0 -> single step only, held=1 until release; raising repeat_en mid-hold -> step on next cycle.
REQ-031 Issue 16 single presses -> step_count wraps 15 -> 0; clr_count coincident with a step -> step=1, step_count=0.
REQ-032 Key held low across RSTb deassert -> no step; release then press -> one step.
REQ-033 RSTb pulsed low in REPEAT one cycle before expiry -> no step, outputs at reset values, FSM IDLE.
